// File: rtl/rv_pkg.sv
// Shared core definitions: datapath width, the canonical nop encoding and
// the instruction-fetch FSM state type.
package rv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    VALID,
    TRAP
  } fetch_state_e;
endpackage

// File: rtl/pc_fetch.sv
// Architectural PC register and single-outstanding instruction fetch FSM.
// It issues one request per PC, holds the fetched word until the core advances, and traps on a misaligned PC.
module pc_fetch
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCNext,
  input  logic        advance,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic        instr_valid,
  output logic        misaligned
);

  fetch_state_e    state, state_n;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] instr_q;
  logic            req_q, vld_q, mis_q;
  logic            capture, take;

  assign take    = (state == VALID) && advance;
  assign capture = ((state == REQ) && imem_gnt && imem_rvalid) ||
                   ((state == WAIT) && imem_rvalid);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = REQ;
      REQ:   if (imem_gnt) state_n = imem_rvalid ? VALID : WAIT;
      WAIT:  if (imem_rvalid) state_n = VALID;
      VALID: if (advance) state_n = (PCNext[1:0] == 2'b00) ? REQ : TRAP;
      TRAP:  state_n = TRAP;
      default: state_n = IDLE;
    endcase
  end

  // Strobes are flopped from the next state so no input reaches them combinationally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      pc_q    <= RESET_VECTOR;
      instr_q <= NOP_INSTR;
      req_q   <= 1'b0;
      vld_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state <= state_n;
      req_q <= (state_n == REQ);
      vld_q <= (state_n == VALID);
      mis_q <= (state_n == TRAP);
      if (take)    pc_q    <= PCNext;
      if (capture) instr_q <= imem_rdata;
    end
  end

  assign PC          = pc_q;
  assign PCPlus4     = pc_q + 32'd4;
  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign Instr       = instr_q;
  assign instr_valid = vld_q;
  assign misaligned  = mis_q;

  a_rv_aligned: assert property (@(posedge clk) RESET_VECTOR[1:0] == 2'b00)
    else $error("pc_fetch: RESET_VECTOR 0x%08h is not word-aligned", RESET_VECTOR);

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: every expected value below is hand-derived from the fetch protocol.
module tb_pc_fetch;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCNext;
  logic        advance;
  logic [31:0] PC, PCPlus4, imem_addr, Instr, imem_rdata;
  logic        imem_req, imem_gnt, imem_rvalid, instr_valid, misaligned;

  int n_cmp = 0;
  int n_err = 0;

  pc_fetch #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .PCNext(PCNext), .advance(advance),
    .PC(PC), .PCPlus4(PCPlus4), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .Instr(Instr), .instr_valid(instr_valid), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pc"},   PC,          32'h0);
    chk({tag, "_ins"},  Instr,       32'h0000_0013);
    chk({tag, "_iv"},   instr_valid, 32'h0);
    chk({tag, "_mis"},  misaligned,  32'h0);
    chk({tag, "_req"},  imem_req,    32'h0);
  endtask

  initial begin
    reset = 1'b1; PCNext = 32'h0; advance = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    #1;
    chk_reset_state("rst");
    step(); step();
    reset = 1'b0;

    // back-to-back fetch, same-cycle gnt+rvalid, advance held high
    imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hA0; advance = 1'b1; PCNext = 32'h4;
    step();
    chk("b2b_req0",  imem_req,    32'h1);
    chk("b2b_addr0", imem_addr,   32'h0);
    chk("b2b_iv0",   instr_valid, 32'h0);
    step();
    chk("b2b_iv1",   instr_valid, 32'h1);
    chk("b2b_ins1",  Instr,       32'hA0);
    chk("b2b_req1",  imem_req,    32'h0);
    step();
    chk("b2b_addr4", imem_addr,   32'h4);
    chk("b2b_iv2",   instr_valid, 32'h0);
    imem_rdata = 32'hA1; PCNext = 32'h8;   // advance in REQ must be ignored
    step();
    chk("b2b_pc4",   PC,          32'h4);
    chk("b2b_iv3",   instr_valid, 32'h1);
    chk("b2b_ins3",  Instr,       32'hA1);
    step();
    chk("b2b_addr8", imem_addr,   32'h8);
    chk("b2b_req8",  imem_req,    32'h1);

    // grant withheld for 3 cycles, then gnt without rvalid -> WAIT
    imem_gnt = 1'b0; imem_rvalid = 1'b0; PCNext = 32'h30;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_req",  imem_req,    32'h1);
      chk("stall_addr", imem_addr,   32'h8);
      chk("stall_iv",   instr_valid, 32'h0);
    end
    imem_gnt = 1'b1;
    step();
    chk("wait_req", imem_req,    32'h0);
    chk("wait_iv",  instr_valid, 32'h0);
    imem_gnt = 1'b0; imem_rdata = 32'hDEAD;
    step();
    chk("wait2_iv",  instr_valid, 32'h0);
    chk("wait2_ins", Instr,       32'hA1);
    imem_rvalid = 1'b1; imem_rdata = 32'hB0;
    step();
    chk("wait_cap_iv",  instr_valid, 32'h1);
    chk("wait_cap_ins", Instr,       32'hB0);
    chk("wait_cap_pc",  PC,          32'h8);

    // hold in VALID at PC=0x10 with advance low
    advance = 1'b1; PCNext = 32'h10; imem_rvalid = 1'b0;
    step();
    chk("hold_addr", imem_addr, 32'h10);
    advance = 1'b0; imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hC0;
    step();
    imem_rdata = 32'hDEAD_BEEF; PCNext = 32'h44;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_ins", Instr,       32'hC0);
      chk("hold_pc",  PC,          32'h10);
      chk("hold_iv",  instr_valid, 32'h1);
    end

    // PC wrap
    advance = 1'b1; PCNext = 32'hFFFF_FFFC;
    step();
    chk("wrap_pc",   PC,      32'hFFFF_FFFC);
    chk("wrap_p4",   PCPlus4, 32'h0);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    advance = 1'b0; imem_rdata = 32'hD0;
    step();
    chk("wrap_iv", instr_valid, 32'h1);
    advance = 1'b1; PCNext = 32'h0;
    step();
    chk("wrap_next_addr", imem_addr, 32'h0);
    chk("wrap_next_req",  imem_req,  32'h1);
    advance = 1'b0; imem_rdata = 32'hE0;
    step();
    chk("pre_trap_iv", instr_valid, 32'h1);

    // misaligned target -> sticky TRAP
    advance = 1'b1; PCNext = 32'h0000_0102;
    step();
    chk("trap_pc",  PC,          32'h102);
    chk("trap_mis", misaligned,  32'h1);
    chk("trap_req", imem_req,    32'h0);
    chk("trap_iv",  instr_valid, 32'h0);
    PCNext = 32'h200;
    for (int i = 0; i < 4; i++) begin
      imem_gnt = i[0]; imem_rvalid = ~i[0]; advance = i[1];
      step();
      chk("trap_stay_mis", misaligned, 32'h1);
      chk("trap_stay_req", imem_req,   32'h0);
      chk("trap_stay_pc",  PC,         32'h102);
    end

    // asynchronous reset in WAIT
    reset = 1'b1;
    #1;
    chk_reset_state("rst2");
    step();
    reset = 1'b0; advance = 1'b0; imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hF0;
    step();
    step();
    chk("rw_ins", Instr, 32'hF0);
    advance = 1'b1; PCNext = 32'h40;
    step();
    chk("rw_addr", imem_addr, 32'h40);
    advance = 1'b0; imem_rvalid = 1'b0;
    step();
    chk("rw_wait_req", imem_req, 32'h0);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_state("rst3");
    step();
    reset = 1'b0; imem_gnt = 1'b0;
    step();
    chk("rv_req",  imem_req,  32'h1);
    chk("rv_addr", imem_addr, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
